gpio_cmd_queue: RTL and testbench

Parametrised successor to the single-register GPIO digit latch. It conditions the microcontroller's `load` strobe and `digit` bus with optional synchronisers and a minimum-high-time glitch filter. It captures one word per accepted strobe into a DEPTH-entry FIFO and presents the words to the stepper/VGA consumers over a valid/ready handshake. `curr_digit` holds the most recently consumed word, so existing consumers of a held digit keep working.

---
 rtl/gpio_cmd_queue.sv | 126 ++++++++++++
 tb/tb_gpio_cmd_queue.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_cmd_queue.sv
// GPIO digit capture: conditioned load strobe feeding a DEPTH-entry word FIFO.
// Define GPIO_SYNC_EN to add two-flop synchronisers on load and digit.
module gpio_cmd_queue #(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 4,
    parameter int MIN_HIGH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           digit,
    input  logic                       load,
    input  logic                       out_ready,
    input  logic                       clr_ovf,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_digit,
    output logic [WIDTH-1:0]           curr_digit,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int HW = $clog2(MIN_HIGH+1);

    localparam logic [HW-1:0] HI_MAX   = HW'(MIN_HIGH);
    localparam logic [HW-1:0] HI_ACC   = HW'(MIN_HIGH-1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic             load_s;
    logic [WIDTH-1:0] digit_s;

`ifdef GPIO_SYNC_EN
    logic [1:0]       load_q;
    logic [WIDTH-1:0] digit_q1;
    logic [WIDTH-1:0] digit_q2;

    always_ff @(posedge clk) begin
        if (reset) begin
            load_q   <= '0;
            digit_q1 <= '0;
            digit_q2 <= '0;
        end else begin
            load_q   <= {load_q[0], load};
            digit_q1 <= digit;
            digit_q2 <= digit_q1;
        end
    end

    assign load_s  = load_q[1];
    assign digit_s = digit_q2;
`else
    assign load_s  = load;
    assign digit_s = digit;
`endif

    logic [HW-1:0]    hi_cnt;
    logic             accept;
    logic             full;
    logic             push;
    logic             pop;
    logic             drop;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    // Saturating high-time counter: one accept per pulse, on its MIN_HIGH-th cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_cnt <= '0;
        end else if (!load_s) begin
            hi_cnt <= '0;
        end else if (hi_cnt != HI_MAX) begin
            hi_cnt <= hi_cnt + HW'(1);
        end
    end

    assign accept    = load_s && (hi_cnt == HI_ACC);
    assign full      = (count == FULL_CNT);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign push      = accept && (!full || pop);
    assign drop      = accept && full && !pop;
    assign out_digit = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= digit_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            curr_digit <= '0;
        end else if (pop) begin
            curr_digit <= out_digit;
        end
    end

    // A drop in the same cycle as a clear leaves the flag set
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gpio_cmd_queue.sv
// Directed bench for gpio_cmd_queue (WIDTH=4, DEPTH=4, MIN_HIGH=2).
// Latencies follow the build: GPIO_SYNC_EN adds two edges.
module tb_gpio_cmd_queue;

    localparam int MH = 2;
`ifdef GPIO_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    // Edge (counting the first one that samples load high as 1) where the push lands
    localparam int LAT = MH + SYNC;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] digit;
    logic       load;
    logic       out_ready;
    logic       clr_ovf;
    logic       out_valid;
    logic [3:0] out_digit;
    logic [3:0] curr_digit;
    logic [2:0] count;
    logic       overflow;

    int n_cmp = 0;
    int n_bad = 0;

    gpio_cmd_queue #(
        .WIDTH(4),
        .DEPTH(4),
        .MIN_HIGH(MH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .digit(digit),
        .load(load),
        .out_ready(out_ready),
        .clr_ovf(clr_ovf),
        .out_valid(out_valid),
        .out_digit(out_digit),
        .curr_digit(curr_digit),
        .count(count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [3:0] d);
        digit = d;
        load  = 1'b1;
        repeat (LAT) tick();
        load = 1'b0;
        repeat (SYNC + 1) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid: got %b want 0", out_valid);
        end
        n_cmp++;
        if (count !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_count: got %0d want 0", count);
        end
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ovf: got %b want 0", overflow);
        end
        n_cmp++;
        if (curr_digit !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_curr: got %h want 0", curr_digit);
        end
        n_cmp++;
        if (out_digit !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_out: got %h want 0", out_digit);
        end
    endtask

    task automatic test_single_word();
        logic [5:0] seen;
        digit = 4'h7;
        load  = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            seen[e] = out_valid;
        end
        load = 1'b0;
        n_cmp++;
        if (seen[LAT-1] !== 1'b0) begin
            n_bad++;
            $display("FAIL single_early: valid %b at edge %0d want 0", seen[LAT-1], LAT-1);
        end
        n_cmp++;
        if (seen[5] !== 1'b1) begin
            n_bad++;
            $display("FAIL single_valid: valid %b at edge 5 want 1", seen[5]);
        end
        repeat (SYNC + 2) tick();
        n_cmp++;
        if (count !== 3'd1) begin
            n_bad++;
            $display("FAIL single_count: got %0d want 1", count);
        end
        n_cmp++;
        if (out_digit !== 4'h7) begin
            n_bad++;
            $display("FAIL single_digit: got %h want 7", out_digit);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (curr_digit !== 4'h7) begin
            n_bad++;
            $display("FAIL single_curr: got %h want 7", curr_digit);
        end
        n_cmp++;
        if (count !== 3'd0) begin
            n_bad++;
            $display("FAIL single_drain: got %0d want 0", count);
        end
    endtask

    task automatic test_glitch();
        digit = 4'hC;
        load  = 1'b1;
        tick();
        load = 1'b0;
        repeat (SYNC + 3) tick();
        n_cmp++;
        if (count !== 3'd0) begin
            n_bad++;
            $display("FAIL glitch_count: got %0d want 0", count);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch_valid: got %b want 0", out_valid);
        end
    endtask

    task automatic test_fill_overflow();
        logic [3:0] exp_w [4];
        exp_w[0] = 4'h3;
        exp_w[1] = 4'h5;
        exp_w[2] = 4'h9;
        exp_w[3] = 4'h2;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(exp_w[i]);
        n_cmp++;
        if (count !== 3'd4 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL fill_full: count %0d ovf %b want 4 0", count, overflow);
        end
        push_word(4'h6);
        n_cmp++;
        if (count !== 3'd4) begin
            n_bad++;
            $display("FAIL ovf_count: got %0d want 4", count);
        end
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_flag: got %b want 1", overflow);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out_digit !== exp_w[i]) begin
                n_bad++;
                $display("FAIL fifo_order[%0d]: got %h want %h", i, out_digit, exp_w[i]);
            end
            tick();
        end
        out_ready = 1'b0;
        n_cmp++;
        if (curr_digit !== 4'h2) begin
            n_bad++;
            $display("FAIL fifo_curr: got %h want 2", curr_digit);
        end
        n_cmp++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL fifo_empty: count %0d valid %b want 0 0", count, out_valid);
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_clear: got %b want 0", overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [3:0] exp_w [4];
        exp_w[0] = 4'h2;
        exp_w[1] = 4'h3;
        exp_w[2] = 4'h4;
        exp_w[3] = 4'hA;
        for (int i = 1; i <= 4; i++) push_word(4'(i));
        digit = 4'hA;
        load  = 1'b1;
        repeat (LAT - 1) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        load = 1'b0;
        n_cmp++;
        if (count !== 3'd4) begin
            n_bad++;
            $display("FAIL pp_count: got %0d want 4", count);
        end
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL pp_ovf: got %b want 0", overflow);
        end
        n_cmp++;
        if (curr_digit !== 4'h1) begin
            n_bad++;
            $display("FAIL pp_curr: got %h want 1", curr_digit);
        end
        repeat (SYNC + 1) tick();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out_digit !== exp_w[i]) begin
                n_bad++;
                $display("FAIL pp_order[%0d]: got %h want %h", i, out_digit, exp_w[i]);
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_ovf_collision();
        for (int i = 1; i <= 4; i++) push_word(4'(i));
        digit = 4'h5;
        load  = 1'b1;
        repeat (LAT - 1) tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        load = 1'b0;
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL coll_set: got %b want 1", overflow);
        end
        n_cmp++;
        if (count !== 3'd4) begin
            n_bad++;
            $display("FAIL coll_count: got %0d want 4", count);
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL coll_clear: got %b want 0", overflow);
        end
        repeat (SYNC + 1) tick();
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        n_cmp++;
        if (curr_digit !== 4'h4 || count !== 3'd0) begin
            n_bad++;
            $display("FAIL coll_drain: curr %h count %0d want 4 0", curr_digit, count);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 3; i++) push_word(4'(i));
        n_cmp++;
        if (count !== 3'd3) begin
            n_bad++;
            $display("FAIL mid_pre: got %0d want 3", count);
        end
        digit = 4'h8;
        load  = 1'b1;
        repeat (LAT - 1) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (count !== 3'd0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_rst_ctl: count %0d valid %b ovf %b want 0 0 0",
                     count, out_valid, overflow);
        end
        n_cmp++;
        if (out_digit !== 4'h0 || curr_digit !== 4'h0) begin
            n_bad++;
            $display("FAIL mid_rst_dat: out %h curr %h want 0 0", out_digit, curr_digit);
        end
        repeat (LAT - 1) tick();
        n_cmp++;
        if (count !== 3'd0) begin
            n_bad++;
            $display("FAIL mid_early: got %0d want 0", count);
        end
        tick();
        n_cmp++;
        if (count !== 3'd1 || out_digit !== 4'h8) begin
            n_bad++;
            $display("FAIL mid_repush: count %0d out %h want 1 8", count, out_digit);
        end
        load = 1'b0;
        repeat (SYNC + 2) tick();
        n_cmp++;
        if (count !== 3'd1) begin
            n_bad++;
            $display("FAIL mid_single: got %0d want 1", count);
        end
    endtask

    initial begin
        reset     = 1'b1;
        digit     = 4'h0;
        load      = 1'b0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        test_reset();
        test_single_word();
        test_glitch();
        test_fill_overflow();
        test_full_push_pop();
        test_ovf_collision();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
